// File: rtl/nihilist_stream_core.sv
// Streaming Nihilist cipher over the 5x5 Polybius square "MATEI/BCDFG/HKLNO/PQRSU/VWXYZ".
// Runtime key load, per-message encrypt/decrypt, one registered output stage with valid/ready.
module nihilist_stream_core #(
  parameter int KEY_MAX_LEN = 16,
  parameter int KL_W        = $clog2(KEY_MAX_LEN + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic            key_wr,
  input  logic [7:0]      key_char,
  input  logic            key_clr,
  output logic [KL_W-1:0] key_len,
  output logic            key_err,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [7:0]      s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [7:0]      m_data,
  output logic            m_last,
  output logic            m_err,
  output logic            busy
);

  localparam int IDX_W = (KEY_MAX_LEN > 1) ? $clog2(KEY_MAX_LEN) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Table position 10*row+col of an uppercase letter; 0 marks an invalid byte.
  function automatic logic [5:0] char_pos(input logic [7:0] c);
    logic [5:0] p;
    case (c)
      8'h4D: p = 6'd11; // M
      8'h41: p = 6'd12; // A
      8'h54: p = 6'd13; // T
      8'h45: p = 6'd14; // E
      8'h49: p = 6'd15; // I
      8'h4A: p = 6'd15; // J folds onto I
      8'h42: p = 6'd21;
      8'h43: p = 6'd22;
      8'h44: p = 6'd23;
      8'h46: p = 6'd24;
      8'h47: p = 6'd25;
      8'h48: p = 6'd31;
      8'h4B: p = 6'd32;
      8'h4C: p = 6'd33;
      8'h4E: p = 6'd34;
      8'h4F: p = 6'd35;
      8'h50: p = 6'd41;
      8'h51: p = 6'd42;
      8'h52: p = 6'd43;
      8'h53: p = 6'd44;
      8'h55: p = 6'd45;
      8'h56: p = 6'd51;
      8'h57: p = 6'd52;
      8'h58: p = 6'd53;
      8'h59: p = 6'd54;
      8'h5A: p = 6'd55;
      default: p = 6'd0;
    endcase
    return p;
  endfunction

  // Letter at (row, col) of the square, both 1..5.
  function automatic logic [7:0] pos_char(input logic [2:0] row, input logic [2:0] col);
    logic [7:0] c;
    case ({row, col})
      6'o11: c = 8'h4D;
      6'o12: c = 8'h41;
      6'o13: c = 8'h54;
      6'o14: c = 8'h45;
      6'o15: c = 8'h49;
      6'o21: c = 8'h42;
      6'o22: c = 8'h43;
      6'o23: c = 8'h44;
      6'o24: c = 8'h46;
      6'o25: c = 8'h47;
      6'o31: c = 8'h48;
      6'o32: c = 8'h4B;
      6'o33: c = 8'h4C;
      6'o34: c = 8'h4E;
      6'o35: c = 8'h4F;
      6'o41: c = 8'h50;
      6'o42: c = 8'h51;
      6'o43: c = 8'h52;
      6'o44: c = 8'h53;
      6'o45: c = 8'h55;
      6'o51: c = 8'h56;
      6'o52: c = 8'h57;
      6'o53: c = 8'h58;
      6'o54: c = 8'h59;
      6'o55: c = 8'h5A;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_t            state_r;
  logic              mode_r;
  logic [IDX_W-1:0]  key_idx_r;
  logic [5:0]        key_mem_r [KEY_MAX_LEN];
  logic [KL_W-1:0]   key_len_r;
  logic              key_err_r;
  logic              m_valid_r;
  logic [7:0]        m_data_r;
  logic              m_last_r;
  logic              m_err_r;

  logic              s_ready_s;
  logic              accept_s;
  logic              first_s;
  logic              mode_use_s;
  logic [IDX_W-1:0]  idx_use_s;
  logic [IDX_W-1:0]  idx_next_s;
  logic [5:0]        key_pos_s;
  logic [5:0]        in_pos_s;
  logic [5:0]        wr_pos_s;
  logic [8:0]        diff_s;
  logic [8:0]        tens_s;
  logic [8:0]        ones_s;
  logic [7:0]        xl_data_s;
  logic              xl_err_s;

  assign s_ready_s = (key_len_r != {KL_W{1'b0}}) && (!m_valid_r || m_ready);
  assign accept_s  = s_valid && s_ready_s;
  assign wr_pos_s  = char_pos(key_char);
  assign in_pos_s  = char_pos(s_data);

  // A beat seen while idle opens a message: it uses the live mode and key index 0.
  always_comb begin
    first_s    = (state_r == ST_IDLE);
    mode_use_s = mode_r;
    idx_use_s  = key_idx_r;
    if (first_s) begin
      mode_use_s = mode;
      idx_use_s  = {IDX_W{1'b0}};
    end else begin
      mode_use_s = mode_r;
      idx_use_s  = key_idx_r;
    end
    if (KL_W'(idx_use_s) == key_len_r - KL_W'(1)) begin
      idx_next_s = {IDX_W{1'b0}};
    end else begin
      idx_next_s = idx_use_s + IDX_W'(1);
    end
    key_pos_s = key_mem_r[idx_use_s];
  end

  // Translate the current input byte against the active key position.
  always_comb begin
    xl_data_s = 8'h00;
    xl_err_s  = 1'b0;
    diff_s    = {1'b0, s_data} - {3'b000, key_pos_s};
    tens_s    = diff_s / 9'd10;
    ones_s    = diff_s % 9'd10;
    if (mode_use_s == 1'b0) begin
      if (in_pos_s == 6'd0) begin
        xl_err_s = 1'b1;
      end else begin
        xl_data_s = {2'b00, in_pos_s} + {2'b00, key_pos_s};
      end
    end else begin
      // diff_s[8] set means the key position exceeded the cipher number.
      if (diff_s[8] || (tens_s < 9'd1) || (tens_s > 9'd5) ||
          (ones_s < 9'd1) || (ones_s > 9'd5)) begin
        xl_err_s = 1'b1;
      end else begin
        xl_data_s = pos_char(tens_s[2:0], ones_s[2:0]);
      end
    end
  end

  // Message FSM, key index and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      mode_r    <= 1'b0;
      key_idx_r <= {IDX_W{1'b0}};
      m_valid_r <= 1'b0;
      m_data_r  <= 8'h00;
      m_last_r  <= 1'b0;
      m_err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        m_valid_r <= 1'b1;
        m_data_r  <= xl_data_s;
        m_last_r  <= s_last;
        m_err_r   <= xl_err_s;
        mode_r    <= mode_use_s;
        if (s_last) begin
          state_r   <= ST_IDLE;
          key_idx_r <= {IDX_W{1'b0}};
        end else begin
          state_r   <= ST_STREAM;
          key_idx_r <= idx_next_s;
        end
      end else if (m_ready) begin
        m_valid_r <= 1'b0;
      end
    end
  end

  // Key storage: appends and clears are honoured only between messages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_len_r <= {KL_W{1'b0}};
      key_err_r <= 1'b0;
      for (int i = 0; i < KEY_MAX_LEN; i++) begin
        key_mem_r[i] <= 6'd0;
      end
    end else if (state_r == ST_IDLE) begin
      if (key_clr) begin
        key_len_r <= {KL_W{1'b0}};
        key_err_r <= 1'b0;
      end else if (key_wr) begin
        if ((wr_pos_s != 6'd0) && (key_len_r != KL_W'(KEY_MAX_LEN))) begin
          key_mem_r[key_len_r[IDX_W-1:0]] <= wr_pos_s;
          key_len_r <= key_len_r + KL_W'(1);
        end else begin
          key_err_r <= 1'b1;
        end
      end
    end
  end

  assign s_ready = s_ready_s;
  assign key_len = key_len_r;
  assign key_err = key_err_r;
  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign m_last  = m_last_r;
  assign m_err   = m_err_r;
  assign busy    = (state_r == ST_STREAM);

endmodule

// File: tb/tb_nihilist_stream_core.sv
// Directed bench for nihilist_stream_core: inputs driven and outputs sampled on the falling edge.
module tb_nihilist_stream_core;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic       key_wr;
  logic [7:0] key_char;
  logic       key_clr;
  logic [4:0] key_len;
  logic       key_err;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_err;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  nihilist_stream_core #(.KEY_MAX_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .key_wr(key_wr), .key_char(key_char), .key_clr(key_clr),
    .key_len(key_len), .key_err(key_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_err(m_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic load_key(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      key_wr   = 1'b1;
      key_char = s[i];
      @(negedge clk);
      key_wr   = 1'b0;
    end
  endtask

  task automatic clear_key();
    @(negedge clk);
    key_clr = 1'b1;
    @(negedge clk);
    key_clr = 1'b0;
  endtask

  // One beat with m_ready high; checks acceptance and the translated output one cycle later.
  task automatic beat(input string tag, input logic [7:0] d, input logic last,
                      input logic [7:0] exp_d, input logic exp_err);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    #1;
    chk({tag, "_rdy"}, 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk({tag, "_v"}, 32'(m_valid), 32'd1);
    chk({tag, "_d"}, 32'(m_data), 32'(exp_d));
    chk({tag, "_l"}, 32'(m_last), 32'(last));
    chk({tag, "_e"}, 32'(m_err), 32'(exp_err));
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; key_wr = 1'b0; key_char = 8'h00; key_clr = 1'b0;
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_mdata", 32'(m_data), 32'd0);
    chk("rst_mlast", 32'(m_last), 32'd0);
    chk("rst_merr", 32'(m_err), 32'd0);
    chk("rst_keylen", 32'(key_len), 32'd0);
    chk("rst_keyerr", 32'(key_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sready", 32'(s_ready), 32'd0);
    rst_n = 1'b1;

    // PARASCHIV = 41 12 43 12 44 22 31 15 51
    load_key("PARASCHIV");
    chk("k9_len", 32'(key_len), 32'd9);
    chk("k9_err", 32'(key_err), 32'd0);
    mode = 1'b0;
    beat("encM", "M", 1'b0, 8'd52, 1'b0);
    chk("enc_busy", 32'(busy), 32'd1);
    beat("encA", "A", 1'b0, 8'd24, 1'b0);
    beat("encT", "T", 1'b0, 8'd56, 1'b0);
    beat("encE", "E", 1'b0, 8'd26, 1'b0);
    beat("encI", "I", 1'b1, 8'd59, 1'b0);
    chk("enc_busy_end", 32'(busy), 32'd0);

    mode = 1'b1;
    beat("dec52", 8'd52, 1'b0, "M", 1'b0);
    beat("dec24", 8'd24, 1'b0, "A", 1'b0);
    beat("dec56", 8'd56, 1'b0, "T", 1'b0);
    beat("dec26", 8'd26, 1'b0, "E", 1'b0);
    beat("dec59", 8'd59, 1'b1, "I", 1'b0);

    // AB = 12 21, M = 11
    clear_key();
    load_key("AB");
    chk("kab_len", 32'(key_len), 32'd2);
    mode = 1'b0;
    beat("wrap0", "M", 1'b0, 8'd23, 1'b0);
    beat("wrap1", "M", 1'b0, 8'd32, 1'b0);
    beat("wrap2", "M", 1'b0, 8'd23, 1'b0);
    beat("wrap3", "M", 1'b0, 8'd32, 1'b0);
    beat("wrap4", "M", 1'b1, 8'd23, 1'b0);
    beat("newmsg", "M", 1'b1, 8'd23, 1'b0);

    // P = 41
    clear_key();
    load_key("P");
    mode = 1'b0;
    beat("enc_bad", "1", 1'b1, 8'd0, 1'b1);
    mode = 1'b1;
    beat("dec_under", 8'd5, 1'b1, 8'd0, 1'b1);
    beat("dec_row0", 8'd48, 1'b1, 8'd0, 1'b1);
    beat("dec_ok", 8'd52, 1'b1, "M", 1'b0);

    // Backpressure: MATE with key P -> 52 53 54 55
    mode = 1'b0;
    @(negedge clk);
    s_valid = 1'b1; s_data = "M"; s_last = 1'b0;
    @(negedge clk);
    s_data = "A"; m_ready = 1'b0;
    #1;
    chk("bp_data0", 32'(m_data), 32'd52);
    chk("bp_rdy0", 32'(s_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_rdy", 32'(s_ready), 32'd0);
      chk("bp_hold_v", 32'(m_valid), 32'd1);
      chk("bp_hold_d", 32'(m_data), 32'd52);
      chk("bp_hold_l", 32'(m_last), 32'd0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    chk("bp_A_v", 32'(m_valid), 32'd1);
    chk("bp_A_d", 32'(m_data), 32'd53);
    beat("bpT", "T", 1'b0, 8'd54, 1'b0);
    beat("bpE", "E", 1'b1, 8'd55, 1'b0);
    @(negedge clk);
    chk("drain_v", 32'(m_valid), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);

    // J stored as I (15): A(12)+15 = 27
    clear_key();
    load_key("J");
    chk("kj_len", 32'(key_len), 32'd1);
    mode = 1'b0;
    beat("kj_enc", "A", 1'b1, 8'd27, 1'b0);
    load_key("1");
    chk("kbad_err", 32'(key_err), 32'd1);
    chk("kbad_len", 32'(key_len), 32'd1);
    clear_key();
    chk("clr_err", 32'(key_err), 32'd0);
    chk("clr_len", 32'(key_len), 32'd0);
    for (int i = 0; i < 16; i++) load_key("A");
    chk("full_len", 32'(key_len), 32'd16);
    chk("full_err", 32'(key_err), 32'd0);
    load_key("A");
    chk("over_len", 32'(key_len), 32'd16);
    chk("over_err", 32'(key_err), 32'd1);

    // Key write during a message is ignored; B = 21, M+B = 32
    clear_key();
    load_key("B");
    beat("str0", "M", 1'b0, 8'd32, 1'b0);
    chk("str_busy", 32'(busy), 32'd1);
    load_key("C");
    chk("str_wr_len", 32'(key_len), 32'd1);
    chk("str_wr_err", 32'(key_err), 32'd0);

    // Reset with a beat in flight
    @(negedge clk);
    s_valid = 1'b1; s_data = "M"; s_last = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    chk("mid_v", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v", 32'(m_valid), 32'd0);
    chk("mid_rst_d", 32'(m_data), 32'd0);
    chk("mid_rst_l", 32'(m_last), 32'd0);
    chk("mid_rst_e", 32'(m_err), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_len", 32'(key_len), 32'd0);
    chk("mid_rst_kerr", 32'(key_err), 32'd0);
    chk("mid_rst_rdy", 32'(s_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
